// File: rtl/single_divide_v_s_seq.sv
`default_nettype none
// ============================================================================
// single_divide_v_s_seq : divides a LENGTH-element float vector by one scalar,
// reusing an external WIDTH-lane divider chunk by chunk.   Rev 1.0
// ============================================================================
module single_divide_v_s_seq #(
    parameter int WIDTH  = 4,
    parameter int LENGTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] vector_a     [LENGTH],
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] vector_c     [LENGTH],
    output logic        div_start,
    output logic [31:0] div_vector_a [WIDTH],
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_vector_c [WIDTH]
);

    localparam int NCHUNK = (LENGTH + WIDTH - 1) / WIDTH;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] chunk;
    logic [31:0]   a_buf     [LENGTH];
    logic [31:0]   chunk_mat [NCHUNK][WIDTH];
    logic          accept;
    logic          chunk_back;

    assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
    assign chunk_back = (state == S_WAIT) && div_done;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_ISSUE;
            end
            S_ISSUE: begin
                busy       = 1'b1;
                div_start  = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (div_done) next_state = (chunk == LAST_CHUNK) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = start ? S_ISSUE : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operands are captured only on an accepted start; chunk advances per result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            chunk <= '0;
            div_b <= '0;
            for (int e = 0; e < LENGTH; e++) a_buf[e] <= '0;
        end else if (accept) begin
            chunk <= '0;
            div_b <= b;
            for (int e = 0; e < LENGTH; e++) a_buf[e] <= vector_a[e];
        end else if (chunk_back && (chunk != LAST_CHUNK)) begin
            chunk <= chunk + 1'b1;
        end
    end

    // Padding lanes of a partial final chunk are tied to zero.
    for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            if (k * WIDTH + i < LENGTH) begin : g_live
                assign chunk_mat[k][i] = a_buf[k * WIDTH + i];
            end else begin : g_pad
                assign chunk_mat[k][i] = '0;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_out
        assign div_vector_a[i] = chunk_mat[chunk][i];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int e = 0; e < LENGTH; e++) vector_c[e] <= '0;
        end else if (chunk_back) begin
            for (int e = 0; e < LENGTH; e++) begin
                if (chunk == CW'(e / WIDTH)) vector_c[e] <= div_vector_c[e % WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_single_divide_v_s_seq.sv
`default_nettype none
// ============================================================================
// tb_single_divide_v_s_seq : scoreboard bench with a fixed-latency divider
// model attached to an 8-element and a 6-element sequencer.   Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_single_divide_v_s_seq;

    localparam int W   = 4;
    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        start8, start6;
    logic [31:0] va8 [8];
    logic [31:0] va6 [6];
    logic [31:0] b8, b6;
    logic        busy8, done8, ds8, busy6, done6, ds6;
    logic [31:0] vc8 [8];
    logic [31:0] vc6 [6];
    logic [31:0] dva8 [W];
    logic [31:0] dva6 [W];
    logic [31:0] db8, db6;
    logic        dd8 = 1'b0;
    logic        dd6 = 1'b0;
    logic [31:0] dvc8 [W] = '{default: 32'h0};
    logic [31:0] dvc6 [W] = '{default: 32'h0};

    int total = 0;
    int bad   = 0;
    int starts8 = 0;
    int starts6 = 0;
    logic [255:0] q8 [$];
    logic [255:0] q6 [$];

    single_divide_v_s_seq #(.WIDTH(W), .LENGTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .vector_a(va8), .b(b8),
        .busy(busy8), .done(done8), .vector_c(vc8), .div_start(ds8),
        .div_vector_a(dva8), .div_b(db8), .div_done(dd8), .div_vector_c(dvc8));

    single_divide_v_s_seq #(.WIDTH(W), .LENGTH(6)) dut6 (
        .clk(clk), .rstn(rstn), .start(start6), .vector_a(va6), .b(b6),
        .busy(busy6), .done(done6), .vector_c(vc6), .div_start(ds6),
        .div_vector_a(dva6), .div_b(db6), .div_done(dd6), .div_vector_c(dvc6));

    function automatic logic [63:0] s2d(input logic [31:0] s);
        if (s[30:23] == 8'h0) return {s[31], 63'h0};
        return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'h0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        if (d[62:52] == 11'h0) return {d[63], 31'h0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] bb);
        real ra, rb;
        if (bb[30:0] == 31'h0) begin
            if (a[30:0] == 31'h0) return 32'h7FC00000;
            return {a[31] ^ bb[31], 8'hFF, 23'h0};
        end
        ra = $bitstoreal(s2d(a));
        rb = $bitstoreal(s2d(bb));
        return d2s($realtobits(ra / rb));
    endfunction

    function automatic logic [255:0] pack8(input logic [31:0] v [8]);
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = v[i];
        return r;
    endfunction

    function automatic logic [255:0] pack6(input logic [31:0] v [6]);
        logic [255:0] r = '0;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = v[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Divider models: result appears LAT+1 cycles after div_start, not reset.
    logic [31:0] ma8 [W];
    logic [31:0] ma6 [W];
    logic [31:0] mb8, mb6;
    int mcnt8 = 0;
    int mcnt6 = 0;

    always @(posedge clk) begin
        dd8 <= 1'b0;
        if (ds8) begin
            ma8   <= dva8;
            mb8   <= db8;
            mcnt8 <= LAT;
        end else if (mcnt8 > 0) begin
            mcnt8 <= mcnt8 - 1;
            if (mcnt8 == 1) begin
                dd8 <= 1'b1;
                for (int i = 0; i < W; i++) dvc8[i] <= fdiv(ma8[i], mb8);
            end
        end
    end

    always @(posedge clk) begin
        dd6 <= 1'b0;
        if (ds6) begin
            ma6   <= dva6;
            mb6   <= db6;
            mcnt6 <= LAT;
        end else if (mcnt6 > 0) begin
            mcnt6 <= mcnt6 - 1;
            if (mcnt6 == 1) begin
                dd6 <= 1'b1;
                for (int i = 0; i < W; i++) dvc6[i] <= fdiv(ma6[i], mb6);
            end
        end
    end

    always @(negedge clk) begin
        logic [255:0] e;
        if (!rstn) begin
            starts8 = 0;
        end else begin
            if (ds8) starts8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("done8_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q8.pop_front();
                    for (int i = 0; i < 8; i++) chk($sformatf("vc8[%0d]", i), vc8[i], e[i*32 +: 32]);
                    chk("div_start8_count", 32'(starts8), 32'd2);
                end
                starts8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [255:0] e;
        if (!rstn) begin
            starts6 = 0;
        end else begin
            if (ds6) begin
                if (starts6 == 1) begin
                    chk("pad_lane2", dva6[2], 32'h0);
                    chk("pad_lane3", dva6[3], 32'h0);
                end
                starts6++;
            end
            if (done6) begin
                if (q6.size() == 0) begin
                    chk("done6_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q6.pop_front();
                    for (int i = 0; i < 6; i++) chk($sformatf("vc6[%0d]", i), vc6[i], e[i*32 +: 32]);
                    chk("div_start6_count", 32'(starts6), 32'd2);
                end
                starts6 = 0;
            end
        end
    end

    task automatic issue8(input logic [31:0] a [8], input logic [31:0] bb);
        start8 = 1'b1;
        va8    = a;
        b8     = bb;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done8(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 200);
        if (!done8) chk({name, "_timeout"}, 32'd0, 32'd1);
        else chk({name, "_busy_in_done"}, 32'(busy8), 32'd0);
    endtask

    logic [31:0] a1 [8], e1 [8], a3 [8], e3 [8], a5 [8];
    logic [31:0] a2 [6], e2 [6];

    initial begin
        a1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        e1 = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000,
               32'h40200000, 32'h40400000, 32'h40600000, 32'h40800000};
        a3 = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h40000000,
               32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        e3 = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800000,
               32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h7F800000};
        a5 = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        a2 = '{32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000};
        e2 = '{32'h3E800000, 32'h3F000000, 32'h3F400000,
               32'h3F800000, 32'h3FA00000, 32'h3FC00000};

        rstn = 1'b0; start8 = 1'b0; start6 = 1'b0;
        va8 = '{default: 32'h0}; va6 = '{default: 32'h0}; b8 = '0; b6 = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_div_start", 32'(ds8), 32'd0);
        chk("rst_div_b", db8, 32'h0);
        chk("rst_div_a0", dva8[0], 32'h0);
        chk("rst_vc8_0", vc8[0], 32'h0);
        chk("rst_vc8_7", vc8[7], 32'h0);

        // Basic 8-element run
        q8.push_back(pack8(e1));
        issue8(a1, 32'h40000000);
        chk("busy_after_start", 32'(busy8), 32'd1);
        wait_done8("run1");

        // Divide by zero passes the divider's special values through
        q8.push_back(pack8(e3));
        issue8(a3, 32'h00000000);
        wait_done8("divzero");

        // Partial final chunk on the 6-element instance
        begin
            int n = 0;
            q6.push_back(pack6(e2));
            start6 = 1'b1; va6 = a2; b6 = 32'h40800000;
            @(negedge clk);
            start6 = 1'b0;
            do begin
                @(negedge clk);
                n++;
            end while (!done6 && n < 200);
            if (!done6) chk("run6_timeout", 32'd0, 32'd1);
        end

        // Start during WAIT is ignored
        q8.push_back(pack8(e1));
        issue8(a1, 32'h40000000);
        repeat (2) @(negedge clk);
        start8 = 1'b1; va8 = a5; b8 = 32'h41000000;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8("ignored_start");

        // Start in the done cycle is accepted back-to-back
        q8.push_back(pack8(e1));
        issue8(a1, 32'h40000000);
        wait_done8("before_b2b");
        q8.push_back(pack8(a5));
        start8 = 1'b1; va8 = a5; b8 = 32'h3F800000;
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_issue_div_start", 32'(ds8), 32'd1);
        chk("b2b_issue_busy", 32'(busy8), 32'd1);
        wait_done8("b2b");

        // Reset during WAIT of chunk 0, then a late div_done arrives
        issue8(a1, 32'h40000000);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("abort_busy", 32'(busy8), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("abort_vc8[%0d]", i), vc8[i], 32'h0);
        begin
            int n = 0;
            while (!dd8 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!dd8) chk("late_done_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        chk("late_done_no_pulse", 32'(done8), 32'd0);
        chk("late_done_no_write", vc8[0], 32'h0);
        repeat (3) @(negedge clk);

        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q6_drained", 32'(q6.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
